// File: rtl/fdtd_axi_pkg.sv
// Shared AXI4 constants and FSM state type for the FDTD memory movers.
package fdtd_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // 4 KB page expressed in 32-bit words
  localparam int unsigned PAGE_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wt_state_e;

  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/fdtd_wt_burst_calc.sv
// Beat count of the next burst: min(MAX_BURST, remaining words, words left in 4 KB page).
module fdtd_wt_burst_calc
  import fdtd_axi_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic [9:0]           addr,
  input  logic [LEN_WIDTH-1:0] rem,
  output logic [8:0]           beats
);

  localparam int unsigned CW = (LEN_WIDTH > 11) ? LEN_WIDTH : 11;

  logic [CW-1:0] room;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] m;

  always_comb begin
    room  = CW'(PAGE_WORDS) - CW'(addr);
    rem_w = CW'(rem);
    m     = CW'(MAX_BURST);
    if (rem_w < m) m = rem_w;
    if (room < m)  m = room;
    beats = 9'(m);
  end

endmodule

// File: rtl/fdtd_mem_burst_wt.sv
// AXI4 INCR burst write master for bulk FDTD field write-back.
// Optional FDTD_MEM_BURST_WT_RESP_CHECK_EN: flag SLVERR/DECERR write responses on err_o.
module fdtd_mem_burst_wt
  import fdtd_axi_pkg::*;
#(
  parameter int unsigned AXI4_ADDR_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH = 32,
  parameter int unsigned AXI4_ID_WIDTH   = 16,
  parameter int unsigned AXI4_USER_WIDTH = 10,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,

  output logic [AXI4_ID_WIDTH-1:0]     AWID_o,
  output logic [AXI4_ADDR_WIDTH-1:0]   AWADDR_o,
  output logic [7:0]                   AWLEN_o,
  output logic [2:0]                   AWSIZE_o,
  output logic [1:0]                   AWBURST_o,
  output logic                         AWLOCK_o,
  output logic [3:0]                   AWCACHE_o,
  output logic [2:0]                   AWPROT_o,
  output logic [3:0]                   AWREGION_o,
  output logic [3:0]                   AWQOS_o,
  output logic [AXI4_USER_WIDTH-1:0]   AWUSER_o,
  output logic                         AWVALID_o,
  input  logic                         AWREADY_i,

  output logic [AXI4_DATA_WIDTH-1:0]   WDATA_o,
  output logic [AXI4_DATA_WIDTH/8-1:0] WSTRB_o,
  output logic                         WLAST_o,
  output logic [AXI4_USER_WIDTH-1:0]   WUSER_o,
  output logic                         WVALID_o,
  input  logic                         WREADY_i,

  input  logic [AXI4_ID_WIDTH-1:0]     BID_i,
  input  logic [1:0]                   BRESP_i,
  input  logic [AXI4_USER_WIDTH-1:0]   BUSER_i,
  input  logic                         BVALID_i,
  output logic                         BREADY_o,

  input  logic                         cmd_valid_i,
  input  logic [AXI4_ADDR_WIDTH-3:0]   cmd_word_addr_i,
  input  logic [LEN_WIDTH-1:0]         cmd_len_i,
  output logic                         cmd_ready_o,

  input  logic                         wt_valid_i,
  input  logic [AXI4_DATA_WIDTH-1:0]   wt_data_i,
  output logic                         wt_ready_o,

  output logic                         done_o,
  output logic                         err_o
);

  localparam int unsigned WAW = AXI4_ADDR_WIDTH - 2;

  wt_state_e            state, state_nxt;
  logic [WAW-1:0]       addr_r;
  logic [LEN_WIDTH-1:0] rem_r;
  logic [8:0]           blen_r;
  logic [8:0]           beat_r;
  logic                 done_r;

  logic [WAW-1:0]       addr_adv;
  logic [LEN_WIDTH-1:0] rem_left;
  logic [9:0]           calc_addr;
  logic [LEN_WIDTH-1:0] calc_rem;
  logic [8:0]           calc_beats;
  logic                 last_beat;
  logic                 w_hs;

  assign addr_adv  = addr_r + WAW'(blen_r);
  assign rem_left  = rem_r - LEN_WIDTH'(blen_r);
  assign last_beat = (beat_r == blen_r - 9'd1);
  assign w_hs      = (state == ST_W) && wt_valid_i && WREADY_i;

  // Size the next burst from the values that will be in addr_r/rem_r on AW entry,
  // so blen_r is already valid in the first AW cycle.
  assign calc_addr = (state == ST_IDLE) ? cmd_word_addr_i[9:0] : addr_adv[9:0];
  assign calc_rem  = (state == ST_IDLE) ? cmd_len_i : rem_left;

  fdtd_wt_burst_calc #(
    .MAX_BURST (MAX_BURST),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_calc (
    .addr  (calc_addr),
    .rem   (calc_rem),
    .beats (calc_beats)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready_o = 1'b0;
    AWVALID_o   = 1'b0;
    WVALID_o    = 1'b0;
    WLAST_o     = 1'b0;
    wt_ready_o  = 1'b0;
    BREADY_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i && (cmd_len_i != '0)) state_nxt = ST_AW;
      end
      ST_AW: begin
        AWVALID_o = 1'b1;
        if (AWREADY_i) state_nxt = ST_W;
      end
      ST_W: begin
        WVALID_o   = wt_valid_i;
        wt_ready_o = WREADY_i;
        WLAST_o    = last_beat;
        if (w_hs && last_beat) state_nxt = ST_B;
      end
      ST_B: begin
        BREADY_o = 1'b1;
        if (BVALID_i) state_nxt = (rem_left != '0) ? ST_AW : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      addr_r <= '0;
      rem_r  <= '0;
      blen_r <= '0;
      beat_r <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            addr_r <= cmd_word_addr_i;
            rem_r  <= cmd_len_i;
            blen_r <= calc_beats;
            beat_r <= '0;
            if (cmd_len_i == '0) done_r <= 1'b1;
          end
        end
        ST_W: begin
          if (w_hs) beat_r <= beat_r + 9'd1;
        end
        ST_B: begin
          if (BVALID_i) begin
            addr_r <= addr_adv;
            rem_r  <= rem_left;
            blen_r <= calc_beats;
            beat_r <= '0;
            if (rem_left == '0) done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o = done_r;

`ifdef FDTD_MEM_BURST_WT_RESP_CHECK_EN
  logic err_r;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err_r <= 1'b0;
    end else if ((state == ST_IDLE) && cmd_valid_i) begin
      err_r <= 1'b0;
    end else if ((state == ST_B) && BVALID_i &&
                 ((BRESP_i == AXI_RESP_SLVERR) || (BRESP_i == AXI_RESP_DECERR))) begin
      err_r <= 1'b1;
    end
  end
  assign err_o = err_r;

  logic unused_b;
  assign unused_b = ^{BID_i, BUSER_i};
`else
  assign err_o = 1'b0;

  logic unused_b;
  assign unused_b = ^{BID_i, BUSER_i, BRESP_i};
`endif

  assign AWID_o     = '0;
  assign AWADDR_o   = {addr_r, 2'b00};
  assign AWLEN_o    = 8'(blen_r - 9'd1);
  assign AWSIZE_o   = axi_size(AXI4_DATA_WIDTH);
  assign AWBURST_o  = AXI_BURST_INCR;
  assign AWLOCK_o   = 1'b0;
  assign AWCACHE_o  = '0;
  assign AWPROT_o   = '0;
  assign AWREGION_o = '0;
  assign AWQOS_o    = '0;
  assign AWUSER_o   = '0;

  assign WDATA_o    = wt_data_i;
  assign WSTRB_o    = '1;
  assign WUSER_o    = '0;

endmodule

// File: tb/tb_fdtd_mem_burst_wt.sv
// Directed bench for fdtd_mem_burst_wt with a small AXI write slave and data source.
module tb_fdtd_mem_burst_wt;
  import fdtd_axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  always #5 ACLK = ~ACLK;

  logic [15:0] AWID_o;
  logic [31:0] AWADDR_o;
  logic [7:0]  AWLEN_o;
  logic [2:0]  AWSIZE_o;
  logic [1:0]  AWBURST_o;
  logic        AWLOCK_o;
  logic [3:0]  AWCACHE_o;
  logic [2:0]  AWPROT_o;
  logic [3:0]  AWREGION_o;
  logic [3:0]  AWQOS_o;
  logic [9:0]  AWUSER_o;
  logic        AWVALID_o, AWREADY_i;
  logic [31:0] WDATA_o;
  logic [3:0]  WSTRB_o;
  logic        WLAST_o;
  logic [9:0]  WUSER_o;
  logic        WVALID_o, WREADY_i;
  logic [15:0] BID_i;
  logic [1:0]  BRESP_i;
  logic [9:0]  BUSER_i;
  logic        BVALID_i, BREADY_o;
  logic        cmd_valid_i;
  logic [29:0] cmd_word_addr_i;
  logic [15:0] cmd_len_i;
  logic        cmd_ready_o;
  logic        wt_valid_i;
  logic [31:0] wt_data_i;
  logic        wt_ready_o;
  logic        done_o, err_o;

  fdtd_mem_burst_wt #(
    .AXI4_ADDR_WIDTH (32),
    .AXI4_DATA_WIDTH (32),
    .AXI4_ID_WIDTH   (16),
    .AXI4_USER_WIDTH (10),
    .MAX_BURST       (16),
    .LEN_WIDTH       (16)
  ) dut (
    .ACLK (ACLK), .ARESETn (ARESETn),
    .AWID_o (AWID_o), .AWADDR_o (AWADDR_o), .AWLEN_o (AWLEN_o), .AWSIZE_o (AWSIZE_o),
    .AWBURST_o (AWBURST_o), .AWLOCK_o (AWLOCK_o), .AWCACHE_o (AWCACHE_o), .AWPROT_o (AWPROT_o),
    .AWREGION_o (AWREGION_o), .AWQOS_o (AWQOS_o), .AWUSER_o (AWUSER_o),
    .AWVALID_o (AWVALID_o), .AWREADY_i (AWREADY_i),
    .WDATA_o (WDATA_o), .WSTRB_o (WSTRB_o), .WLAST_o (WLAST_o), .WUSER_o (WUSER_o),
    .WVALID_o (WVALID_o), .WREADY_i (WREADY_i),
    .BID_i (BID_i), .BRESP_i (BRESP_i), .BUSER_i (BUSER_i), .BVALID_i (BVALID_i), .BREADY_o (BREADY_o),
    .cmd_valid_i (cmd_valid_i), .cmd_word_addr_i (cmd_word_addr_i), .cmd_len_i (cmd_len_i),
    .cmd_ready_o (cmd_ready_o),
    .wt_valid_i (wt_valid_i), .wt_data_i (wt_data_i), .wt_ready_o (wt_ready_o),
    .done_o (done_o), .err_o (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  bit   rnd = 0;
  bit   cmd_pend = 0;
  int   cyc = 0;
  int   slverr_burst = -1;
  int   bpend, b_idx, aw_cnt, w_cnt, b_cnt, done_cnt, done_cyc, acc_cyc, first_aw_cyc;
  int   aw_seen, stab_viol, cross_viol, data_err;
  logic err_at_done, err_pre;
  bit   aw_hold;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  int          last_q[$];

  function automatic logic [31:0] pat(input int i);
    return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  task automatic clear_stats();
    bpend = 0; b_idx = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0;
    done_cyc = -1; acc_cyc = -1; first_aw_cyc = -1; aw_seen = 0;
    stab_viol = 0; cross_viol = 0; data_err = 0; aw_hold = 0;
    err_at_done = 1'bx; err_pre = 1'bx;
    aw_addr_q.delete(); aw_len_q.delete(); last_q.delete();
  endtask

  // One clock: drive at negedge, observe the handshakes that the next posedge will take.
  task automatic cycle();
    @(negedge ACLK);
    cmd_valid_i = cmd_pend;
    if (rnd) begin
      AWREADY_i  = 1'($urandom_range(0, 1));
      WREADY_i   = 1'($urandom_range(0, 1));
      wt_valid_i = 1'($urandom_range(0, 1));
      BVALID_i   = (bpend > 0) && ($urandom_range(0, 2) != 0);
    end else begin
      AWREADY_i  = 1'b1;
      WREADY_i   = 1'b1;
      wt_valid_i = 1'b1;
      BVALID_i   = (bpend > 0);
    end
    wt_data_i = pat(w_cnt);
    BRESP_i   = (b_idx == slverr_burst) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    #1;
    cyc++;
    if (done_o) begin done_cnt++; done_cyc = cyc; err_at_done = err_o; end
    if (aw_hold && (!AWVALID_o || AWADDR_o !== hold_addr || AWLEN_o !== hold_len)) stab_viol++;
    aw_hold   = AWVALID_o && !AWREADY_i;
    hold_addr = AWADDR_o;
    hold_len  = AWLEN_o;
    if (AWVALID_o) begin
      aw_seen++;
      if (first_aw_cyc < 0) first_aw_cyc = cyc;
    end
    if (cmd_valid_i && cmd_ready_o) begin cmd_pend = 0; acc_cyc = cyc; end
    if (AWVALID_o && AWREADY_i) begin
      aw_cnt++;
      aw_addr_q.push_back(AWADDR_o);
      aw_len_q.push_back(AWLEN_o);
      if ((AWADDR_o & 32'hFFF) + (32'(AWLEN_o) + 1) * 4 > 32'h1000) cross_viol++;
    end
    if (WVALID_o && WREADY_i) begin
      if (WDATA_o !== pat(w_cnt) || !wt_ready_o) data_err++;
      if (WLAST_o) begin last_q.push_back(w_cnt); bpend++; end
      w_cnt++;
    end
    if (BVALID_i && BREADY_o) begin
      if (b_idx == slverr_burst) err_pre = err_o;
      bpend--; b_cnt++; b_idx++;
    end
  endtask

  task automatic issue(input logic [29:0] a, input logic [15:0] l);
    clear_stats();
    cmd_word_addr_i = a;
    cmd_len_i       = l;
    cmd_pend        = 1;
  endtask

  task automatic run_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin cycle(); n++; end
    if (done_cnt == 0) check({tag, "_timeout"}, 1, 0);
    repeat (3) cycle();
  endtask

  initial begin
    ARESETn = 1'b0;
    AWREADY_i = 0; WREADY_i = 0; wt_valid_i = 0; wt_data_i = '0;
    BID_i = '0; BRESP_i = '0; BUSER_i = '0; BVALID_i = 0;
    cmd_valid_i = 0; cmd_word_addr_i = '0; cmd_len_i = '0;
    clear_stats();

    // reset values
    repeat (2) @(negedge ACLK);
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_outputs", {AWVALID_o, WVALID_o, WLAST_o, BREADY_o, wt_ready_o, done_o, err_o}, 0);
    check("rst_awlen", AWLEN_o, 8'hFF);
    check("rst_awaddr", AWADDR_o, 0);
    check("rst_consts", {AWSIZE_o, AWBURST_o, WSTRB_o}, {3'd2, 2'b01, 4'hF});
    ARESETn = 1'b1;

    // 40 words at word 0x100: 16/16/8 beats, best-case timing
    issue(30'h100, 16'd40);
    run_done("a", 200);
    check("a_aw_cnt", aw_cnt, 3);
    check("a_aw0", {aw_addr_q[0], aw_len_q[0]}, {32'h400, 8'd15});
    check("a_aw1", {aw_addr_q[1], aw_len_q[1]}, {32'h440, 8'd15});
    check("a_aw2", {aw_addr_q[2], aw_len_q[2]}, {32'h480, 8'd7});
    check("a_w_cnt", w_cnt, 40);
    check("a_last_cnt", last_q.size(), 3);
    check("a_last_pos", {last_q[0], last_q[1], last_q[2]}, {32'd15, 32'd31, 32'd39});
    check("a_b_cnt", b_cnt, 3);
    check("a_done_cnt", done_cnt, 1);
    check("a_aw_latency", first_aw_cyc - acc_cyc, 1);
    check("a_done_latency", done_cyc - acc_cyc, 47);
    check("a_data", data_err, 0);
    check("a_err", err_o, 0);

    // 4 KB boundary split
    issue(30'h3FA, 16'd10);
    run_done("b", 200);
    check("b_aw_cnt", aw_cnt, 2);
    check("b_aw0", {aw_addr_q[0], aw_len_q[0]}, {32'hFE8, 8'd5});
    check("b_aw1", {aw_addr_q[1], aw_len_q[1]}, {32'h1000, 8'd3});
    check("b_cross", cross_viol, 0);
    check("b_w_cnt", w_cnt, 10);
    check("b_done_cnt", done_cnt, 1);

    // zero-length command
    issue(30'h55, 16'd0);
    run_done("z", 20);
    repeat (3) cycle();
    check("z_no_aw", aw_seen, 0);
    check("z_done_latency", done_cyc - acc_cyc, 1);
    check("z_done_cnt", done_cnt, 1);
    check("z_cmd_ready", cmd_ready_o, 1);

    // random stalls, SLVERR on the second burst
    rnd = 1;
    issue(30'h20, 16'd33);
    slverr_burst = 1;
    run_done("r", 3000);
    check("r_aw_cnt", aw_cnt, 3);
    check("r_aw_addr", {aw_addr_q[0], aw_addr_q[1], aw_addr_q[2]}, {32'h80, 32'hC0, 32'h100} );
    check("r_aw_len", {aw_len_q[0], aw_len_q[1], aw_len_q[2]}, {8'd15, 8'd15, 8'd0});
    check("r_w_cnt", w_cnt, 33);
    check("r_b_cnt", b_cnt, 3);
    check("r_last_pos", {last_q[0], last_q[1], last_q[2]}, {32'd15, 32'd31, 32'd32});
    check("r_data", data_err, 0);
    check("r_aw_stable", stab_viol, 0);
    check("r_done_cnt", done_cnt, 1);
    check("r_err_before", err_pre, 0);
`ifdef FDTD_MEM_BURST_WT_RESP_CHECK_EN
    check("r_err_done", err_at_done, 1);
    check("r_err_hold", err_o, 1);
`else
    check("r_err_done", err_at_done, 0);
    check("r_err_hold", err_o, 0);
`endif
    slverr_burst = -1;
    rnd = 0;
    issue(30'h0, 16'd0);
    run_done("e", 20);
    check("e_err_cleared", err_o, 0);

    // reset while beat 5 of a burst is on the W channel
    issue(30'h0, 16'd16);
    begin
      int n = 0;
      while (w_cnt < 5 && n < 50) begin cycle(); n++; end
    end
    check("m_reached_beat5", w_cnt, 5);
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    check("m_beat5_valid", WVALID_o, 1);
    @(negedge ACLK);
    #1;
    check("m_cmd_ready", cmd_ready_o, 1);
    check("m_outputs", {AWVALID_o, WVALID_o, WLAST_o, BREADY_o, wt_ready_o, done_o, err_o}, 0);
    ARESETn = 1'b1;

    // recovery after mid-burst reset
    issue(30'h10, 16'd3);
    run_done("p", 50);
    check("p_aw", {aw_cnt, aw_addr_q[0], aw_len_q[0]}, {32'd1, 32'h40, 8'd2});
    check("p_w", {w_cnt, last_q[0]}, {32'd3, 32'd2});
    check("p_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
